apb_spi_bridge: RTL and testbench

//  Parametrised APB3 master that drives a CoreSPI peripheral. Sits between user logic and the SPI's APB slave port.

---
 rtl/apb_spi_pkg.sv | 10 +
 rtl/apb_spi_if.sv | 17 +
 rtl/apb_spi_rxbuf.sv | 41 ++++
 rtl/apb_spi_bridge.sv | 138 +++++++++++++
 tb/tb_apb_spi_bridge.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_spi_pkg.sv
// apb_spi_pkg: CoreSPI register offsets and bridge FSM states
package apb_spi_pkg;
    localparam logic [7:0] CONTROL  = 8'h00;
    localparam logic [7:0] INTCLEAR = 8'h04;
    localparam logic [7:0] RXDATA   = 8'h08;
    localparam logic [7:0] TXDATA   = 8'h0C;
    localparam logic [7:0] INTMASK  = 8'h10;
    localparam logic [7:0] STAT     = 8'h20;
    typedef enum logic [2:0] {IDLE, CFG_SETUP, CFG_ACCESS, SETUP, ACCESS} state_t;
endpackage

// File: rtl/apb_spi_if.sv
// apb_spi_if: APB3 bus between the bridge (master) and the CoreSPI APB port (slave)
// Signals: PSEL, PENABLE, PWRITE, PADDR, PWDATA (master out); PRDATA, PREADY, PSLVERR (slave out)
interface apb_spi_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;
    modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA, input PRDATA, PREADY, PSLVERR);
    modport slave  (input PSEL, PENABLE, PWRITE, PADDR, PWDATA, output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/apb_spi_rxbuf.sv
// apb_spi_rxbuf: synchronous FIFO buffering frames read from the SPI RX register
// Ports: PCLK, PRESET (sync active-high), push/din write side, pop/dout read side, full, empty
module apb_spi_rxbuf #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(DEPTH);
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("apb_spi_rxbuf: DEPTH must be a power of 2 and >= 2");
    end
    logic [DATA_W-1:0] mem [DEPTH];
    // One extra pointer bit separates full from empty when the indices match
    logic [AW:0] wp, rp;
    logic do_push, do_pop;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = wp == rp;
    assign full    = (wp ^ rp) == {1'b1, {AW{1'b0}}};
    assign dout    = mem[rp[AW-1:0]];
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wp <= '0;
            rp <= '0;
        end else begin
            wp <= wp + {{AW{1'b0}}, do_push};
            rp <= rp + {{AW{1'b0}}, do_pop};
        end
    end
    always_ff @(posedge PCLK) begin
        if (do_push) mem[wp[AW-1:0]] <= din;
    end
endmodule

// File: rtl/apb_spi_bridge.sv
// apb_spi_bridge: APB3 master that configures CoreSPI once, then moves RX/TX frames
// Ports: PCLK, PRESET (sync active-high); apb (APB master modport);
//        SPIRXAVAIL, SPITXRFM (SPI FIFO status); tx_data/tx_valid/tx_ready (TX stream in);
//        rx_data/rx_valid/rx_ready (RX stream out); init_done; err (sticky until PRESET)
// Build option: APB_SPI_TIMEOUT_EN aborts an ACCESS after TIMEOUT cycles without PREADY
module apb_spi_bridge
    import apb_spi_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 8,
    parameter logic [DATA_W-1:0] CTRL_INIT = 'h03,
    parameter int                RX_DEPTH  = 4,
    parameter int                TIMEOUT   = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    apb_spi_if.master         apb,
    input  logic              SPIRXAVAIL,
    input  logic              SPITXRFM,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              init_done,
    output logic              err
);
    if (TIMEOUT < 1) begin : g_timeout_chk
        $error("apb_spi_bridge: TIMEOUT must be >= 1");
    end
    state_t            state, state_n;
    logic [ADDR_W-1:0] paddr, paddr_n;
    logic [DATA_W-1:0] pwdata, pwdata_n;
    logic              pwrite, pwrite_n;
    logic              init_n, err_n;
    logic              tx_pri, tx_pri_n;
    logic              push, full, empty;
    logic              rx_elig, tx_elig, tmo;
    assign apb.PSEL    = state != IDLE;
    assign apb.PENABLE = state == CFG_ACCESS || state == ACCESS;
    assign apb.PWRITE  = pwrite;
    assign apb.PADDR   = paddr;
    assign apb.PWDATA  = pwdata;
    assign rx_valid    = !empty;
    assign rx_elig     = SPIRXAVAIL && !full;
    // A reset edge aborts everything, so never acknowledge a TX frame in that cycle
    assign tx_elig     = tx_valid && SPITXRFM && !PRESET;
`ifdef APB_SPI_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
    logic [CW-1:0] wait_cnt;
    assign tmo = apb.PENABLE && !apb.PREADY && wait_cnt == TMO_LAST;
    always_ff @(posedge PCLK) begin
        wait_cnt <= (PRESET || !apb.PENABLE || apb.PREADY || tmo) ? '0 : wait_cnt + CW'(1);
    end
`else
    assign tmo = 1'b0;
`endif
    apb_spi_rxbuf #(.DATA_W(DATA_W), .DEPTH(RX_DEPTH)) u_rxbuf (
        .PCLK  (PCLK),
        .PRESET(PRESET),
        .push  (push),
        .din   (apb.PRDATA),
        .pop   (rx_ready),
        .dout  (rx_data),
        .full  (full),
        .empty (empty)
    );
    always_comb begin
        state_n  = state;
        paddr_n  = paddr;
        pwdata_n = pwdata;
        pwrite_n = pwrite;
        init_n   = init_done;
        err_n    = err;
        tx_pri_n = tx_pri;
        tx_ready = 1'b0;
        push     = 1'b0;
        case (state)
            IDLE: begin
                if (!init_done) begin
                    state_n  = CFG_SETUP;
                    paddr_n  = ADDR_W'(CONTROL);
                    pwdata_n = CTRL_INIT;
                    pwrite_n = 1'b1;
                end else if (rx_elig && !(tx_elig && tx_pri)) begin
                    // RX normally wins; tx_pri hands the next contested slot to TX
                    state_n  = SETUP;
                    paddr_n  = ADDR_W'(RXDATA);
                    pwrite_n = 1'b0;
                    tx_pri_n = 1'b1;
                end else if (tx_elig) begin
                    state_n  = SETUP;
                    paddr_n  = ADDR_W'(TXDATA);
                    pwdata_n = tx_data;
                    pwrite_n = 1'b1;
                    tx_pri_n = 1'b0;
                    tx_ready = 1'b1;
                end
            end
            CFG_SETUP: state_n = CFG_ACCESS;
            SETUP:     state_n = ACCESS;
            CFG_ACCESS, ACCESS: begin
                if (apb.PREADY) begin
                    // A failed CONTROL write leaves init_done low, so IDLE retries it
                    state_n = IDLE;
                    err_n   = err || apb.PSLVERR;
                    init_n  = init_done || (state == CFG_ACCESS && !apb.PSLVERR);
                    push    = state == ACCESS && !pwrite && !apb.PSLVERR;
                end else if (tmo) begin
                    state_n = IDLE;
                    err_n   = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= IDLE;
            paddr     <= ADDR_W'(CONTROL);
            pwdata    <= '0;
            pwrite    <= 1'b0;
            init_done <= 1'b0;
            err       <= 1'b0;
            tx_pri    <= 1'b0;
        end else begin
            state     <= state_n;
            paddr     <= paddr_n;
            pwdata    <= pwdata_n;
            pwrite    <= pwrite_n;
            init_done <= init_n;
            err       <= err_n;
            tx_pri    <= tx_pri_n;
        end
    end
endmodule

// File: tb/tb_apb_spi_bridge.sv
// tb_apb_spi_bridge: directed self-checking bench for apb_spi_bridge with a simple APB slave model
module tb_apb_spi_bridge;
    logic       PCLK = 1'b0;
    logic       PRESET = 1'b1;
    logic       SPIRXAVAIL = 1'b0;
    logic       SPITXRFM = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       init_done;
    logic       err;
    int         checks = 0;
    int         errors = 0;
    int         wait_n = 0;
    logic       stuck = 1'b0;
    logic       slverr_en = 1'b0;
    int         acc_cnt = 0;
    int         rd_cnt = 0;
    logic [7:0] rd_vals [8] = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    logic [7:0] xa [$];
    logic [7:0] xw [$];

    always #5 PCLK = ~PCLK;

    apb_spi_if #(.ADDR_W(8), .DATA_W(8)) apb ();

    // Slave model: PREADY after wait_n wait states, read data from a fixed table
    assign apb.PREADY  = !stuck && acc_cnt >= wait_n;
    assign apb.PSLVERR = slverr_en && apb.PSEL && apb.PENABLE;
    assign apb.PRDATA  = rd_vals[rd_cnt % 8];

    always @(posedge PCLK) begin
        acc_cnt <= (apb.PSEL && apb.PENABLE && !apb.PREADY) ? acc_cnt + 1 : 0;
        if (apb.PSEL && apb.PENABLE && apb.PREADY) begin
            xa.push_back(apb.PADDR);
            xw.push_back(apb.PWDATA);
            if (!apb.PWRITE) rd_cnt <= rd_cnt + 1;
        end
    end

    apb_spi_bridge dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .apb       (apb),
        .SPIRXAVAIL(SPIRXAVAIL),
        .SPITXRFM  (SPITXRFM),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .init_done (init_done),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    task automatic check_reset(input string tag);
        check({tag, " PSEL"}, apb.PSEL, 0);
        check({tag, " PENABLE"}, apb.PENABLE, 0);
        check({tag, " PWRITE"}, apb.PWRITE, 0);
        check({tag, " PADDR"}, apb.PADDR, 8'h00);
        check({tag, " PWDATA"}, apb.PWDATA, 8'h00);
        check({tag, " tx_ready"}, tx_ready, 0);
        check({tag, " rx_valid"}, rx_valid, 0);
        check({tag, " init_done"}, init_done, 0);
        check({tag, " err"}, err, 0);
    endtask

    initial begin
        int base;
        int k;
        int n;
        logic [7:0] exp_data;
        // Reset and CONTROL programming
        tick(2);
        check_reset("rst");
        PRESET = 1'b0;
        tick(1);
        check("cfg setup PSEL", apb.PSEL, 1);
        check("cfg setup PENABLE", apb.PENABLE, 0);
        check("cfg setup PWRITE", apb.PWRITE, 1);
        check("cfg setup PADDR", apb.PADDR, 8'h00);
        check("cfg setup PWDATA", apb.PWDATA, 8'h03);
        tick(1);
        check("cfg access PENABLE", apb.PENABLE, 1);
        check("cfg access init_done", init_done, 0);
        tick(1);
        check("cfg done PSEL", apb.PSEL, 0);
        check("cfg done init_done", init_done, 1);
        // Single RX read, then fill the buffer
        SPIRXAVAIL = 1'b1;
        tick(1);
        check("rx setup PADDR", apb.PADDR, 8'h08);
        check("rx setup PWRITE", apb.PWRITE, 0);
        check("rx setup PENABLE", apb.PENABLE, 0);
        tick(1);
        check("rx access PENABLE", apb.PENABLE, 1);
        check("rx access rx_valid", rx_valid, 0);
        tick(1);
        check("rx1 rx_valid", rx_valid, 1);
        check("rx1 rx_data", rx_data, 8'hA5);
        check("rx1 PSEL", apb.PSEL, 0);
        tick(15);
        check("rx full reads", rd_cnt, 4);
        check("rx full PSEL", apb.PSEL, 0);
        SPIRXAVAIL = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("rx pop data", rx_data, rd_vals[i]);
            rx_ready = 1'b1;
            tick(1);
        end
        check("rx drained", rx_valid, 0);
        tick(1);
        rx_ready = 1'b0;
        check("rx pop empty", rx_valid, 0);
        // TX write with three wait states
        wait_n = 3;
        tx_data = 8'h3C;
        tx_valid = 1'b1;
        SPITXRFM = 1'b1;
        #1;
        check("tx handshake", tx_ready, 1);
        tick(1);
        check("tx setup tx_ready", tx_ready, 0);
        check("tx setup PADDR", apb.PADDR, 8'h0C);
        check("tx setup PWDATA", apb.PWDATA, 8'h3C);
        check("tx setup PENABLE", apb.PENABLE, 0);
        tx_valid = 1'b0;
        tx_data = 8'h00;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("tx access PENABLE", apb.PENABLE, 1);
            check("tx access PWDATA", apb.PWDATA, 8'h3C);
            check("tx access PADDR", apb.PADDR, 8'h0C);
            check("tx access PWRITE", apb.PWRITE, 1);
        end
        tick(1);
        check("tx done PSEL", apb.PSEL, 0);
        // Fairness: both eligible alternate RX/TX, then reads only
        wait_n = 0;
        tx_data = 8'h5A;
        tx_valid = 1'b1;
        SPIRXAVAIL = 1'b1;
        rx_ready = 1'b1;
        base = xa.size();
        tick(12);
        check("alt count", xa.size() - base, 4);
        for (int i = 0; i < 4 && base + i < xa.size(); i++) begin
            check("alt addr", xa[base + i], (i % 2 == 0) ? 8'h08 : 8'h0C);
            if (i % 2 == 1) check("alt wdata", xw[base + i], 8'h5A);
        end
        SPITXRFM = 1'b0;
        base = xa.size();
        tick(12);
        check("rx only count", xa.size() - base, 4);
        for (int i = 0; i < 4 && base + i < xa.size(); i++) check("rx only addr", xa[base + i], 8'h08);
        SPIRXAVAIL = 1'b0;
        tx_valid = 1'b0;
        tick(3);
        rx_ready = 1'b0;
        check("pre err empty", rx_valid, 0);
        // PSLVERR on a read leaves the buffer untouched
        k = rd_cnt;
        exp_data = rd_vals[k % 8];
        SPIRXAVAIL = 1'b1;
        tick(1);
        SPIRXAVAIL = 1'b0;
        tick(2);
        check("good read rx_data", rx_data, exp_data);
        slverr_en = 1'b1;
        SPIRXAVAIL = 1'b1;
        tick(1);
        SPIRXAVAIL = 1'b0;
        tick(1);
        check("slverr access err", err, 0);
        tick(1);
        slverr_en = 1'b0;
        check("slverr err", err, 1);
        check("slverr rx_valid", rx_valid, 1);
        check("slverr rx_data", rx_data, exp_data);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        check("slverr one entry", rx_valid, 0);
        // Reset in the middle of an ACCESS
        wait_n = 5;
        tx_data = 8'h77;
        tx_valid = 1'b1;
        SPITXRFM = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        tick(1);
        check("mid access PENABLE", apb.PENABLE, 1);
        check("err sticky", err, 1);
        PRESET = 1'b1;
        tick(1);
        check_reset("mid rst");
        wait_n = 0;
        tick(1);
        PRESET = 1'b0;
        n = 0;
        while (!init_done && n < 10) begin
            tick(1);
            n++;
        end
        check("reinit init_done", init_done, 1);
        check("reinit PWDATA", apb.PWDATA, 8'h03);
        check("reinit err", err, 0);
`ifdef APB_SPI_TIMEOUT_EN
        // PREADY stuck low: abort after 16 ACCESS cycles
        stuck = 1'b1;
        tx_data = 8'h99;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (!(apb.PSEL && apb.PENABLE)) break;
            n++;
        end
        check("timeout cycles", n, 16);
        check("timeout PSEL", apb.PSEL, 0);
        check("timeout err", err, 1);
        stuck = 1'b0;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
